// File: rtl/proc_pkg.sv
// Shared processor types: decoded control bundle and
// result-select / register constants used across pipeline stages.
package proc_pkg;

   typedef struct packed {
      logic       alusrc;
      logic       memtoreg;
      logic       regwrite;
      logic       memwrite;
      logic [2:0] aluop;
      logic       imm;
      logic       dir;
      logic [1:0] mush;
      logic       wr;
   } ctrl_bundle_t;

   localparam ctrl_bundle_t CTRL_BUBBLE = '0;

   localparam logic [1:0] MUSH_ALU   = 2'b00;
   localparam logic [1:0] MUSH_SHIFT = 2'b01;
   localparam logic [1:0] MUSH_MUL   = 2'b10;

   localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use comparator: a valid load in EX whose destination
// is read by the instruction in decode. XZR never conflicts.
module load_use_detect
   import proc_pkg::*;
(
   input  logic       ex_valid,
   input  logic       ex_memtoreg,
   input  logic       ex_regwrite,
   input  logic [4:0] ex_rd,
   input  logic       id_valid,
   input  logic [4:0] id_rn,
   input  logic [4:0] id_rm,
   input  logic       id_uses_rm,
   output logic       load_use
);

   logic ex_is_load;
   logic rn_hit;
   logic rm_hit;

   assign ex_is_load = ex_valid & ex_memtoreg & ex_regwrite
                     & (ex_rd != XZR);
   assign rn_hit     = (ex_rd == id_rn);
   assign rm_hit     = id_uses_rm & (ex_rd == id_rm);
   assign load_use   = ex_is_load & id_valid & (rn_hit | rm_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubbles, branch kill
// of the decode slot and a hold while a multi-cycle MUL is in EX.
module id_ex_stage
   import proc_pkg::*;
#(
   parameter int DW         = 64,
   parameter int MUL_CYCLES = 3
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          id_alusrc,
   input  logic          id_memtoreg,
   input  logic          id_regwrite,
   input  logic          id_memwrite,
   input  logic          id_imm,
   input  logic          id_dir,
   input  logic          id_wr,
   input  logic [2:0]    id_aluop,
   input  logic [1:0]    id_mush,
   input  logic          id_valid,
   input  logic [4:0]    id_rn,
   input  logic [4:0]    id_rm,
   input  logic          id_uses_rm,
   input  logic [4:0]    id_rd,
   input  logic [DW-1:0] id_rn_data,
   input  logic [DW-1:0] id_rm_data,
   input  logic [DW-1:0] id_imm_ext,
   input  logic          flush_id,
   output logic          ex_alusrc,
   output logic          ex_memtoreg,
   output logic          ex_regwrite,
   output logic          ex_memwrite,
   output logic          ex_imm,
   output logic          ex_dir,
   output logic          ex_wr,
   output logic [2:0]    ex_aluop,
   output logic [1:0]    ex_mush,
   output logic          ex_valid,
   output logic [4:0]    ex_rn,
   output logic [4:0]    ex_rm,
   output logic [4:0]    ex_rd,
   output logic [DW-1:0] ex_rn_data,
   output logic [DW-1:0] ex_rm_data,
   output logic [DW-1:0] ex_imm_ext,
   output logic          stall_id,
   output logic          mul_busy
);

   localparam int CW = $clog2(MUL_CYCLES + 1);

   ctrl_bundle_t  ctrl_q, ctrl_d;
   logic          valid_q, valid_d;
   logic [4:0]    rn_q, rn_d;
   logic [4:0]    rm_q, rm_d;
   logic [4:0]    rd_q, rd_d;
   logic [DW-1:0] rn_data_q, rn_data_d;
   logic [DW-1:0] rm_data_q, rm_data_d;
   logic [DW-1:0] imm_ext_q, imm_ext_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          kill_q, kill_d;

   logic          load_use;
   logic          hold;
   ctrl_bundle_t  id_ctrl;

   load_use_detect u_lud (
      .ex_valid    (valid_q),
      .ex_memtoreg (ctrl_q.memtoreg),
      .ex_regwrite (ctrl_q.regwrite),
      .ex_rd       (rd_q),
      .id_valid    (id_valid),
      .id_rn       (id_rn),
      .id_rm       (id_rm),
      .id_uses_rm  (id_uses_rm),
      .load_use    (load_use)
   );

   assign hold     = (cnt_q != '0);
   assign mul_busy = hold;
   assign stall_id = hold | (load_use & ~flush_id & ~kill_q);

   // A MUL never writes from memory; this masks an undefined memtoreg.
   always_comb begin
      id_ctrl.alusrc   = id_alusrc;
      id_ctrl.memtoreg = (id_mush == MUSH_MUL) ? 1'b0 : id_memtoreg;
      id_ctrl.regwrite = id_regwrite;
      id_ctrl.memwrite = id_memwrite;
      id_ctrl.aluop    = id_aluop;
      id_ctrl.imm      = id_imm;
      id_ctrl.dir      = id_dir;
      id_ctrl.mush     = id_mush;
      id_ctrl.wr       = id_wr;
   end

   always_comb begin
      ctrl_d    = ctrl_q;
      valid_d   = valid_q;
      rn_d      = rn_q;
      rm_d      = rm_q;
      rd_d      = rd_q;
      rn_data_d = rn_data_q;
      rm_data_d = rm_data_q;
      imm_ext_d = imm_ext_q;
      cnt_d     = cnt_q;
      kill_d    = kill_q;
      if (hold) begin
         cnt_d  = cnt_q - CW'(1);
         kill_d = kill_q | flush_id;
      end else if (flush_id | kill_q | ~id_valid | load_use) begin
         ctrl_d    = CTRL_BUBBLE;
         valid_d   = 1'b0;
         rn_d      = XZR;
         rm_d      = XZR;
         rd_d      = XZR;
         rn_data_d = '0;
         rm_data_d = '0;
         imm_ext_d = '0;
         kill_d    = 1'b0;
      end else begin
         ctrl_d    = id_ctrl;
         valid_d   = 1'b1;
         rn_d      = id_rn;
         rm_d      = id_rm;
         rd_d      = id_rd;
         rn_data_d = id_rn_data;
         rm_data_d = id_rm_data;
         imm_ext_d = id_imm_ext;
         kill_d    = 1'b0;
         if (id_mush == MUSH_MUL && MUL_CYCLES > 1)
            cnt_d = CW'(MUL_CYCLES - 1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ctrl_q    <= CTRL_BUBBLE;
         valid_q   <= 1'b0;
         rn_q      <= '0;
         rm_q      <= '0;
         rd_q      <= '0;
         rn_data_q <= '0;
         rm_data_q <= '0;
         imm_ext_q <= '0;
         cnt_q     <= '0;
         kill_q    <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         valid_q   <= valid_d;
         rn_q      <= rn_d;
         rm_q      <= rm_d;
         rd_q      <= rd_d;
         rn_data_q <= rn_data_d;
         rm_data_q <= rm_data_d;
         imm_ext_q <= imm_ext_d;
         cnt_q     <= cnt_d;
         kill_q    <= kill_d;
      end
   end

   assign ex_alusrc   = ctrl_q.alusrc;
   assign ex_memtoreg = ctrl_q.memtoreg;
   assign ex_regwrite = ctrl_q.regwrite;
   assign ex_memwrite = ctrl_q.memwrite;
   assign ex_imm      = ctrl_q.imm;
   assign ex_dir      = ctrl_q.dir;
   assign ex_wr       = ctrl_q.wr;
   assign ex_aluop    = ctrl_q.aluop;
   assign ex_mush     = ctrl_q.mush;
   assign ex_valid    = valid_q;
   assign ex_rn       = rn_q;
   assign ex_rm       = rm_q;
   assign ex_rd       = rd_q;
   assign ex_rn_data  = rn_data_q;
   assign ex_rm_data  = rm_data_q;
   assign ex_imm_ext  = imm_ext_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized scoreboard bench for id_ex_stage against a
// cycle-level behavioural model of the ID/EX hazard rules.
module tb_id_ex_stage;

   localparam int DW  = 64;
   localparam int MULC = 3;

   typedef struct packed {
      logic          rst_n;
      logic          flush;
      logic          valid;
      logic          alusrc;
      logic          memtoreg;
      logic          regwrite;
      logic          memwrite;
      logic          imm;
      logic          dir;
      logic          wr;
      logic [2:0]    aluop;
      logic [1:0]    mush;
      logic [4:0]    rn;
      logic [4:0]    rm;
      logic          uses_rm;
      logic [4:0]    rd;
      logic [DW-1:0] rn_data;
      logic [DW-1:0] rm_data;
      logic [DW-1:0] imm_ext;
   } in_t;

   typedef struct packed {
      logic          valid;
      logic          alusrc;
      logic          memtoreg;
      logic          regwrite;
      logic          memwrite;
      logic          imm;
      logic          dir;
      logic          wr;
      logic [2:0]    aluop;
      logic [1:0]    mush;
      logic [4:0]    rn;
      logic [4:0]    rm;
      logic [4:0]    rd;
      logic [DW-1:0] rn_data;
      logic [DW-1:0] rm_data;
      logic [DW-1:0] imm_ext;
   } ex_t;

   typedef struct {
      bit  known;
      bit  stall;
      ex_t ex;
      bit  busy;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   in_t s;
   logic ex_alusrc, ex_memtoreg, ex_regwrite, ex_memwrite;
   logic ex_imm, ex_dir, ex_wr, ex_valid, stall_id, mul_busy;
   logic [2:0] ex_aluop;
   logic [1:0] ex_mush;
   logic [4:0] ex_rn, ex_rm, ex_rd;
   logic [DW-1:0] ex_rn_data, ex_rm_data, ex_imm_ext;

   id_ex_stage #(.DW(DW), .MUL_CYCLES(MULC)) dut (
      .clk(clk), .reset_n(s.rst_n),
      .id_alusrc(s.alusrc), .id_memtoreg(s.memtoreg),
      .id_regwrite(s.regwrite), .id_memwrite(s.memwrite),
      .id_imm(s.imm), .id_dir(s.dir), .id_wr(s.wr),
      .id_aluop(s.aluop), .id_mush(s.mush), .id_valid(s.valid),
      .id_rn(s.rn), .id_rm(s.rm), .id_uses_rm(s.uses_rm),
      .id_rd(s.rd), .id_rn_data(s.rn_data),
      .id_rm_data(s.rm_data), .id_imm_ext(s.imm_ext),
      .flush_id(s.flush),
      .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg),
      .ex_regwrite(ex_regwrite), .ex_memwrite(ex_memwrite),
      .ex_imm(ex_imm), .ex_dir(ex_dir), .ex_wr(ex_wr),
      .ex_aluop(ex_aluop), .ex_mush(ex_mush), .ex_valid(ex_valid),
      .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd),
      .ex_rn_data(ex_rn_data), .ex_rm_data(ex_rm_data),
      .ex_imm_ext(ex_imm_ext),
      .stall_id(stall_id), .mul_busy(mul_busy)
   );

   int checks = 0;
   int errors = 0;
   exp_t q[$];
   bit done = 0;

   // model state
   bit  m_known = 0;
   ex_t m_ex;
   int  m_busy = 0;
   bit  m_kill = 0;
   bit  last_stall = 0;
   logic [4:0] last_rd = 5'd0;

   function automatic ex_t bubble_ex();
      ex_t e = '0;
      e.rn = 5'd31;
      e.rm = 5'd31;
      e.rd = 5'd31;
      return e;
   endfunction

   function automatic in_t base();
      in_t i = '0;
      i.rst_n   = 1'b1;
      i.valid   = 1'b1;
      i.rn_data = {$urandom, $urandom};
      i.rm_data = {$urandom, $urandom};
      i.imm_ext = {$urandom, $urandom};
      return i;
   endfunction

   function automatic in_t alu(input logic [2:0] op,
                               input logic [4:0] rd,
                               input logic [4:0] rn,
                               input logic [4:0] rm,
                               input bit useimm);
      in_t i = base();
      i.regwrite = 1'b1;
      i.aluop    = op;
      i.rd       = rd;
      i.rn       = rn;
      i.rm       = rm;
      i.uses_rm  = !useimm;
      i.alusrc   = useimm;
      i.imm      = useimm;
      i.wr       = 1'b1;
      return i;
   endfunction

   function automatic in_t ldur(input logic [4:0] rd,
                                input logic [4:0] rn);
      in_t i = alu(3'b010, rd, rn, 5'd0, 1);
      i.memtoreg = 1'b1;
      return i;
   endfunction

   function automatic in_t mul(input logic [4:0] rd,
                               input logic [4:0] rn,
                               input logic [4:0] rm);
      in_t i = alu(3'b011, rd, rn, rm, 0);
      i.mush     = 2'b10;
      i.memtoreg = 1'bx;
      return i;
   endfunction

   function automatic in_t idle(input bit rst_n);
      in_t i;
      i = 'x;
      i.rst_n = rst_n;
      i.flush = 1'b0;
      i.valid = 1'b0;
      return i;
   endfunction

   function automatic ex_t capture(input in_t i);
      ex_t e;
      e.valid    = 1'b1;
      e.alusrc   = i.alusrc;
      e.memtoreg = (i.mush == 2'b10) ? 1'b0 : i.memtoreg;
      e.regwrite = i.regwrite;
      e.memwrite = i.memwrite;
      e.imm      = i.imm;
      e.dir      = i.dir;
      e.wr       = i.wr;
      e.aluop    = i.aluop;
      e.mush     = i.mush;
      e.rn       = i.rn;
      e.rm       = i.rm;
      e.rd       = i.rd;
      e.rn_data  = i.rn_data;
      e.rm_data  = i.rm_data;
      e.imm_ext  = i.imm_ext;
      return e;
   endfunction

   // Drive one decode cycle, predict, and advance the model.
   task automatic cycle(input in_t i);
      exp_t r;
      bit   lu;
      s = i;
      lu = m_known && m_ex.valid && m_ex.memtoreg &&
           m_ex.regwrite && (m_ex.rd != 5'd31) && i.valid &&
           ((m_ex.rd == i.rn) || (i.uses_rm && m_ex.rd == i.rm));
      r.known = m_known;
      r.stall = (m_busy > 0) || (lu && !i.flush && !m_kill);
      if (!i.rst_n) begin
         m_ex    = '0;
         m_busy  = 0;
         m_kill  = 0;
         m_known = 1;
      end else if (m_known) begin
         if (m_busy > 0) begin
            m_busy = m_busy - 1;
            m_kill = m_kill | i.flush;
         end else if (i.flush || m_kill || !i.valid || lu) begin
            m_ex   = bubble_ex();
            m_kill = 0;
         end else begin
            m_ex = capture(i);
            if (i.mush == 2'b10) m_busy = MULC - 1;
         end
      end
      r.ex   = m_ex;
      r.busy = (m_busy > 0);
      q.push_back(r);
      last_stall = r.stall;
      @(negedge clk);
   endtask

   task automatic issue(input in_t i);
      int n = 0;
      cycle(i);
      i.flush = 1'b0;
      while (last_stall && n < 12) begin
         cycle(i);
         n++;
      end
   endtask

   function automatic in_t rnd();
      in_t i;
      int  k = $urandom_range(0, 5);
      logic [4:0] rd = 5'($urandom);
      logic [4:0] rn = ($urandom_range(0, 1) == 1) ? last_rd
                                                   : 5'($urandom);
      logic [4:0] rm = ($urandom_range(0, 3) == 0) ? last_rd
                                                   : 5'($urandom);
      if ($urandom_range(0, 7) == 0) return idle(1'b1);
      if (k == 0)      i = alu(3'($urandom), rd, rn, rm, 0);
      else if (k == 1) i = ldur(rd, rn);
      else if (k == 2) begin
         i = alu(3'b010, rd, rn, rm, 1);
         i.regwrite = 1'b0;
         i.memwrite = 1'b1;
         i.uses_rm  = 1'b1;
      end else if (k == 3) i = mul(rd, rn, rm);
      else if (k == 4) begin
         i = alu(3'b000, rd, rn, rm, 1);
         i.mush = 2'b01;
         i.dir  = 1'($urandom);
      end else begin
         i = alu(3'b001, rd, rn, rm, 0);
         i.regwrite = 1'b0;
         i.wr       = 1'b0;
      end
      i.flush = ($urandom_range(0, 9) == 0);
      return i;
   endfunction

   // monitor: stall before the edge, EX bundle after it
   initial begin
      exp_t r;
      ex_t  got;
      forever begin
         #2;
         if (q.size() == 0) begin
            if (done) break;
            errors++;
            checks++;
            $display("FAIL scoreboard_empty at %0t", $time);
         end else begin
            r = q.pop_front();
            if (r.known) begin
               checks++;
               if (stall_id !== r.stall) begin
                  errors++;
                  $display("FAIL stall_id t=%0t got %b exp %b",
                           $time, stall_id, r.stall);
               end
            end
            @(posedge clk);
            #1;
            got = {ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite,
                   ex_memwrite, ex_imm, ex_dir, ex_wr, ex_aluop,
                   ex_mush, ex_rn, ex_rm, ex_rd, ex_rn_data,
                   ex_rm_data, ex_imm_ext};
            checks++;
            if (got !== r.ex) begin
               errors++;
               $display("FAIL ex_bundle t=%0t got %h exp %h",
                        $time, got, r.ex);
            end
            checks++;
            if (mul_busy !== r.busy) begin
               errors++;
               $display("FAIL mul_busy t=%0t got %b exp %b",
                        $time, mul_busy, r.busy);
            end
         end
         @(negedge clk);
      end
   end

   initial begin
      in_t i;
      // reset with random decode traffic
      i = alu(3'($urandom), 5'($urandom), 5'($urandom), 5'd2, 0);
      i.rst_n = 1'b0;
      cycle(i);
      i = ldur(5'd4, 5'd1);
      i.rst_n = 1'b0;
      cycle(i);
      // pass-through ADDI
      issue(alu(3'b010, 5'd5, 5'd1, 5'd0, 1));
      // load-use, then same with XZR destination
      issue(ldur(5'd3, 5'd2));
      issue(alu(3'b010, 5'd6, 5'd3, 5'd9, 0));
      issue(ldur(5'd31, 5'd2));
      issue(alu(3'b010, 5'd6, 5'd31, 5'd31, 0));
      issue(ldur(5'd8, 5'd2));
      issue(alu(3'b110, 5'd9, 5'd1, 5'd8, 0));
      // MUL hold, then follower
      issue(mul(5'd7, 5'd1, 5'd2));
      issue(alu(3'b010, 5'd10, 5'd7, 5'd0, 1));
      // flush of SUBS
      i = alu(3'b110, 5'd11, 5'd1, 5'd2, 0);
      i.flush = 1'b1;
      cycle(i);
      // flush pulsed during MUL hold
      issue(mul(5'd12, 5'd1, 5'd2));
      i = alu(3'b010, 5'd13, 5'd1, 5'd0, 1);
      i.flush = 1'b1;
      cycle(i);
      issue(alu(3'b010, 5'd13, 5'd1, 5'd0, 1));
      issue(alu(3'b010, 5'd14, 5'd1, 5'd0, 1));
      // reset mid-MUL
      issue(mul(5'd15, 5'd1, 5'd2));
      cycle(alu(3'b010, 5'd16, 5'd1, 5'd0, 1));
      cycle(idle(1'b0));
      issue(alu(3'b010, 5'd16, 5'd1, 5'd0, 1));
      issue(idle(1'b1));
      // randomized traffic, upstream re-presents while stalled
      i = rnd();
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 79) == 0) begin
            cycle(idle(1'b0));
            i = rnd();
         end else begin
            cycle(i);
            if (last_stall) i.flush = ($urandom_range(0, 9) == 0);
            else begin
               if (i.valid && i.regwrite) last_rd = i.rd;
               i = rnd();
            end
         end
      end
      done = 1;
      #5;
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
